psimd_exec_ctrl: RTL and testbench

//  Sequencer in front of the 4-lane DLFloat16 execution unit (four dlfloat16_top lanes + exception_unit).

---
 rtl/psimd_pkg.sv | 49 ++++
 rtl/psimd_op_decode.sv | 51 +++++
 rtl/psimd_exec_ctrl.sv | 245 ++++++++++++++++++++++++
 tb/tb_psimd_exec_ctrl.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psimd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : psimd_pkg
// Purpose  : Shared types and constants for the packed-SIMD DLFloat16
//            execution controller: opcode encoding, fflags bit positions,
//            dynamic rounding-mode code, execution-unit control bundle and
//            controller state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package psimd_pkg;

  typedef enum logic [3:0] {
    OPC_ADD = 4'd0,
    OPC_SUB = 4'd1,
    OPC_MUL = 4'd2,
    OPC_DIV = 4'd3,
    OPC_FMA = 4'd4,
    OPC_FMS = 4'd5,
    OPC_CMP = 4'd6,
    OPC_F2I = 4'd7,
    OPC_I2F = 4'd8
  } opc_e;

  // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
  localparam int FLAG_NX = 0;
  localparam int FLAG_UF = 1;
  localparam int FLAG_OF = 2;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_NV = 4;

  localparam logic [2:0] RM_DYN = 3'b111;
  localparam int         LANE_W = 16;

  typedef struct packed {
    logic [3:0] ena;
    logic [1:0] sel1;
    logic [2:0] sel2;
    logic       op;
  } eu_ctrl_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

endpackage
`default_nettype wire

// File: rtl/psimd_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : psimd_op_decode
// Purpose  : Combinational opcode decoder. Maps a packed-SIMD opcode and
//            compare function onto the execution-unit ena/sel1/sel2/op
//            controls and flags unsupported opcodes.
// Ports    : opc_i     - instruction opcode
//            cmp_i     - compare function (only used by CMP)
//            ctrl_o    - decoded execution-unit controls
//            illegal_o - opcode not supported
// Revision : 1.0 - initial release
// ============================================================================
module psimd_op_decode
  import psimd_pkg::*;
(
  input  logic [3:0] opc_i,
  input  logic [2:0] cmp_i,
  output eu_ctrl_t   ctrl_o,
  output logic       illegal_o
);

  always_comb begin
    ctrl_o    = '0;
    illegal_o = 1'b0;
    case (opc_i)
      OPC_ADD: ctrl_o.ena = 4'b0001;
      OPC_SUB: begin
        ctrl_o.ena = 4'b0001;
        ctrl_o.op  = 1'b1;
      end
      OPC_MUL: ctrl_o.ena = 4'b0010;
      OPC_DIV: ctrl_o.ena = 4'b0100;
      OPC_FMA: ctrl_o.ena = 4'b1000;
      OPC_FMS: begin
        ctrl_o.ena = 4'b1000;
        ctrl_o.op  = 1'b1;
      end
      // Compare and conversions use the side paths selected by sel1; no
      // arithmetic block is enabled for them.
      OPC_CMP: begin
        ctrl_o.sel1 = 2'b01;
        ctrl_o.sel2 = cmp_i;
      end
      OPC_F2I: ctrl_o.sel1 = 2'b10;
      OPC_I2F: ctrl_o.sel1 = 2'b11;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/psimd_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : psimd_exec_ctrl
// Purpose  : Sequencer in front of the 4-lane DLFloat16 execution unit.
//            Accepts one instruction (valid/ready), drives registered unit
//            controls/operands for EXEC_LAT cycles, captures and lane-merges
//            the result, accumulates sticky fflags and returns the result
//            over a valid/ready handshake.
// Ports    : clk, rst (async, active-high)
//            in_*       - instruction channel (valid/ready + fields)
//            csr_frm    - dynamic rounding mode
//            flush      - abort in-flight op
//            fflags_clr - clear sticky flags
//            out_*      - result channel (valid/ready + data/flags)
//            fflags, op_count - sticky flags, retired legal op counter
//            eu_*       - execution-unit controls, operands and results
// Revision : 1.0 - initial release
// ============================================================================
module psimd_exec_ctrl
  import psimd_pkg::*;
#(
  parameter int REG_WIDTH = 64,
  parameter int EXEC_LAT  = 2,
  parameter int CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_opc,
  input  logic [2:0]             in_rm,
  input  logic [2:0]             in_cmp,
  input  logic [3:0]             in_lane_en,
  input  logic [REG_WIDTH-1:0]   in_src_a,
  input  logic [REG_WIDTH-1:0]   in_src_b,
  input  logic [REG_WIDTH-1:0]   in_src_c,
  input  logic [2*REG_WIDTH-1:0] in_srci,
  input  logic [2:0]             csr_frm,
  input  logic                   flush,
  input  logic                   fflags_clr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [REG_WIDTH-1:0]   out_result,
  output logic [2*REG_WIDTH-1:0] out_resulti,
  output logic [4:0]             out_flags,
  output logic                   out_illegal,
  output logic [4:0]             fflags,
  output logic [CNT_W-1:0]       op_count,
  output logic [3:0]             eu_ena,
  output logic [1:0]             eu_sel1,
  output logic [2:0]             eu_sel2,
  output logic                   eu_op,
  output logic [2:0]             eu_rm,
  output logic [REG_WIDTH-1:0]   eu_data1,
  output logic [REG_WIDTH-1:0]   eu_data2,
  output logic [REG_WIDTH-1:0]   eu_data3,
  output logic [REG_WIDTH-1:0]   eu_datai_0,
  output logic [REG_WIDTH-1:0]   eu_datai_1,
  input  logic [REG_WIDTH-1:0]   eu_dataout_1,
  input  logic [REG_WIDTH-1:0]   eu_dataouti_0,
  input  logic [REG_WIDTH-1:0]   eu_dataouti_1,
  input  logic [3:0]             eu_invalid,
  input  logic [3:0]             eu_inexact,
  input  logic [3:0]             eu_overflow,
  input  logic [3:0]             eu_underflow,
  input  logic [3:0]             eu_div_by_zero
);

  localparam int LANES = REG_WIDTH / LANE_W;
  localparam int LAT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

  state_e                 state_q, state_d;
  logic [LAT_W-1:0]       cnt_q, cnt_d;
  logic [3:0]             lane_en_q, lane_en_d;
  eu_ctrl_t               eu_ctrl_q, eu_ctrl_d;
  logic [2:0]             eu_rm_q, eu_rm_d;
  logic [REG_WIDTH-1:0]   eu_data1_q, eu_data1_d;
  logic [REG_WIDTH-1:0]   eu_data2_q, eu_data2_d;
  logic [REG_WIDTH-1:0]   eu_data3_q, eu_data3_d;
  logic [2*REG_WIDTH-1:0] eu_datai_q, eu_datai_d;
  logic [REG_WIDTH-1:0]   result_q, result_d;
  logic [2*REG_WIDTH-1:0] resulti_q, resulti_d;
  logic [4:0]             flags_q, flags_d;
  logic                   illegal_q, illegal_d;
  logic [4:0]             fflags_q, fflags_d;
  logic [CNT_W-1:0]       op_count_q, op_count_d;

  eu_ctrl_t               w_dec_ctrl;
  logic                   w_opc_illegal;
  logic [2:0]             w_rm;
  logic                   w_illegal;
  logic [REG_WIDTH-1:0]   w_merged;
  logic [4:0]             w_flags;

  psimd_op_decode u_decode (
    .opc_i     (in_opc),
    .cmp_i     (in_cmp),
    .ctrl_o    (w_dec_ctrl),
    .illegal_o (w_opc_illegal)
  );

  // Dynamic rounding is resolved at accept time so a later CSR write cannot
  // affect an op already in flight.
  assign w_rm      = (in_rm == RM_DYN) ? csr_frm : in_rm;
  assign w_illegal = w_opc_illegal || (w_rm == 3'd5) || (w_rm == 3'd6);

  // Disabled lanes pass the src_a lane through unchanged; eu_data1_q still
  // holds src_a while the op is in EXEC.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_merged[g*LANE_W +: LANE_W] = lane_en_q[g] ? eu_dataout_1[g*LANE_W +: LANE_W]
                                                       : eu_data1_q[g*LANE_W +: LANE_W];
  end

  always_comb begin
    w_flags          = '0;
    w_flags[FLAG_NV] = |(eu_invalid     & lane_en_q);
    w_flags[FLAG_DZ] = |(eu_div_by_zero & lane_en_q);
    w_flags[FLAG_OF] = |(eu_overflow    & lane_en_q);
    w_flags[FLAG_UF] = |(eu_underflow   & lane_en_q);
    w_flags[FLAG_NX] = |(eu_inexact     & lane_en_q);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lane_en_d  = lane_en_q;
    eu_ctrl_d  = eu_ctrl_q;
    eu_rm_d    = eu_rm_q;
    eu_data1_d = eu_data1_q;
    eu_data2_d = eu_data2_q;
    eu_data3_d = eu_data3_q;
    eu_datai_d = eu_datai_q;
    result_d   = result_q;
    resulti_d  = resulti_q;
    flags_d    = flags_q;
    illegal_d  = illegal_q;
    op_count_d = op_count_q;
    // Clear takes effect before any OR of a same-cycle capture below.
    fflags_d   = fflags_clr ? 5'd0 : fflags_q;

    if (flush) begin
      state_d       = S_IDLE;
      eu_ctrl_d.ena = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            lane_en_d = in_lane_en;
            if (w_illegal) begin
              illegal_d = 1'b1;
              result_d  = '0;
              resulti_d = '0;
              flags_d   = '0;
              state_d   = S_RESP;
            end else begin
              illegal_d  = 1'b0;
              eu_ctrl_d  = w_dec_ctrl;
              eu_rm_d    = w_rm;
              eu_data1_d = in_src_a;
              eu_data2_d = in_src_b;
              eu_data3_d = in_src_c;
              eu_datai_d = in_srci;
              cnt_d      = LAT_W'(EXEC_LAT - 1);
              state_d    = S_EXEC;
            end
          end
        end
        S_EXEC: begin
          if (cnt_q == '0) begin
            result_d      = w_merged;
            resulti_d     = {eu_dataouti_1, eu_dataouti_0};
            flags_d       = w_flags;
            fflags_d      = fflags_d | w_flags;
            op_count_d    = op_count_q + CNT_W'(1);
            eu_ctrl_d.ena = '0;
            state_d       = S_RESP;
          end else begin
            cnt_d = cnt_q - LAT_W'(1);
          end
        end
        S_RESP: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lane_en_q  <= '0;
      eu_ctrl_q  <= '0;
      eu_rm_q    <= '0;
      eu_data1_q <= '0;
      eu_data2_q <= '0;
      eu_data3_q <= '0;
      eu_datai_q <= '0;
      result_q   <= '0;
      resulti_q  <= '0;
      flags_q    <= '0;
      illegal_q  <= 1'b0;
      fflags_q   <= '0;
      op_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lane_en_q  <= lane_en_d;
      eu_ctrl_q  <= eu_ctrl_d;
      eu_rm_q    <= eu_rm_d;
      eu_data1_q <= eu_data1_d;
      eu_data2_q <= eu_data2_d;
      eu_data3_q <= eu_data3_d;
      eu_datai_q <= eu_datai_d;
      result_q   <= result_d;
      resulti_q  <= resulti_d;
      flags_q    <= flags_d;
      illegal_q  <= illegal_d;
      fflags_q   <= fflags_d;
      op_count_q <= op_count_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE) && !flush;
  assign out_valid   = (state_q == S_RESP);
  assign out_result  = result_q;
  assign out_resulti = resulti_q;
  assign out_flags   = flags_q;
  assign out_illegal = illegal_q;
  assign fflags      = fflags_q;
  assign op_count    = op_count_q;
  assign eu_ena      = eu_ctrl_q.ena;
  assign eu_sel1     = eu_ctrl_q.sel1;
  assign eu_sel2     = eu_ctrl_q.sel2;
  assign eu_op       = eu_ctrl_q.op;
  assign eu_rm       = eu_rm_q;
  assign eu_data1    = eu_data1_q;
  assign eu_data2    = eu_data2_q;
  assign eu_data3    = eu_data3_q;
  assign eu_datai_0  = eu_datai_q[REG_WIDTH-1:0];
  assign eu_datai_1  = eu_datai_q[2*REG_WIDTH-1:REG_WIDTH];

endmodule
`default_nettype wire

// File: tb/tb_psimd_exec_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_psimd_exec_ctrl
// Purpose  : Self-checking bench for psimd_exec_ctrl. A timestamp-based
//            behavioural model tracks the one outstanding op; a per-cycle
//            compare process checks the DUT against it. Directed cases pin
//            literal values, then randomized traffic runs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_psimd_exec_ctrl;

  localparam int EXEC_LAT = 2;
  localparam int CNT_W    = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         in_valid = 0, in_ready, flush = 0, fflags_clr = 0, out_valid, out_ready = 0;
  logic [3:0]   in_opc = 0, in_lane_en = 0;
  logic [2:0]   in_rm = 0, in_cmp = 0, csr_frm = 0;
  logic [63:0]  in_src_a = 0, in_src_b = 0, in_src_c = 0;
  logic [127:0] in_srci = 0;
  logic [63:0]  out_result;
  logic [127:0] out_resulti;
  logic [4:0]   out_flags, fflags;
  logic         out_illegal;
  logic [CNT_W-1:0] op_count;
  logic [3:0]   eu_ena;
  logic [1:0]   eu_sel1;
  logic [2:0]   eu_sel2, eu_rm;
  logic         eu_op;
  logic [63:0]  eu_data1, eu_data2, eu_data3, eu_datai_0, eu_datai_1;
  // Stand-in execution unit outputs, driven by the bench
  logic [63:0]  u_out = 0, u_outi0 = 0, u_outi1 = 0;
  logic [3:0]   u_nv = 0, u_nx = 0, u_of = 0, u_uf = 0, u_dz = 0;

  psimd_exec_ctrl #(.REG_WIDTH(64), .EXEC_LAT(EXEC_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opc(in_opc), .in_rm(in_rm),
    .in_cmp(in_cmp), .in_lane_en(in_lane_en), .in_src_a(in_src_a), .in_src_b(in_src_b),
    .in_src_c(in_src_c), .in_srci(in_srci), .csr_frm(csr_frm), .flush(flush),
    .fflags_clr(fflags_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_resulti(out_resulti), .out_flags(out_flags),
    .out_illegal(out_illegal), .fflags(fflags), .op_count(op_count),
    .eu_ena(eu_ena), .eu_sel1(eu_sel1), .eu_sel2(eu_sel2), .eu_op(eu_op), .eu_rm(eu_rm),
    .eu_data1(eu_data1), .eu_data2(eu_data2), .eu_data3(eu_data3),
    .eu_datai_0(eu_datai_0), .eu_datai_1(eu_datai_1),
    .eu_dataout_1(u_out), .eu_dataouti_0(u_outi0), .eu_dataouti_1(u_outi1),
    .eu_invalid(u_nv), .eu_inexact(u_nx), .eu_overflow(u_of),
    .eu_underflow(u_uf), .eu_div_by_zero(u_dz)
  );

  int n_checks = 0;
  int n_errors = 0;

  function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Decode table {ena[3:0], sel1[1:0], sel2[2:0], op}
  function automatic logic [9:0] ref_ctrl(logic [3:0] opc, logic [2:0] cmp);
    case (opc)
      4'd0: return {4'b0001, 2'b00, 3'b000, 1'b0};
      4'd1: return {4'b0001, 2'b00, 3'b000, 1'b1};
      4'd2: return {4'b0010, 2'b00, 3'b000, 1'b0};
      4'd3: return {4'b0100, 2'b00, 3'b000, 1'b0};
      4'd4: return {4'b1000, 2'b00, 3'b000, 1'b0};
      4'd5: return {4'b1000, 2'b00, 3'b000, 1'b1};
      4'd6: return {4'b0000, 2'b01, cmp,    1'b0};
      4'd7: return {4'b0000, 2'b10, 3'b000, 1'b0};
      4'd8: return {4'b0000, 2'b11, 3'b000, 1'b0};
      default: return 10'd0;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  int           cyc;
  bit           m_busy, m_valid;
  int           m_cap;
  logic [63:0]  m_a, m_b, m_c;
  logic [127:0] m_i;
  logic [3:0]   m_en, m_opc;
  logic [2:0]   m_cmp, m_rm;
  logic [63:0]  e_result;
  logic [127:0] e_resulti;
  logic [4:0]   e_flags, e_fflags, m_nf;
  logic         e_illegal;
  logic [CNT_W-1:0] e_count;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc = 0; m_busy = 0; m_valid = 0; e_fflags = 0; e_count = 0;
      e_result = 0; e_resulti = 0; e_flags = 0; e_illegal = 0;
    end else begin
      cyc++;
      m_nf = fflags_clr ? 5'd0 : e_fflags;
      if (flush) begin
        m_busy = 0; m_valid = 0;
      end else if (m_valid) begin
        if (out_ready) begin m_busy = 0; m_valid = 0; end
      end else if (m_busy) begin
        if (cyc == m_cap) begin
          for (int i = 0; i < 4; i++)
            e_result[16*i +: 16] = m_en[i] ? u_out[16*i +: 16] : m_a[16*i +: 16];
          e_resulti = {u_outi1, u_outi0};
          e_flags   = {|(u_nv & m_en), |(u_dz & m_en), |(u_of & m_en), |(u_uf & m_en), |(u_nx & m_en)};
          m_nf      = m_nf | e_flags;
          e_count   = e_count + 1'b1;
          m_valid   = 1;
        end
      end else if (in_valid) begin
        m_busy = 1;
        m_a = in_src_a; m_b = in_src_b; m_c = in_src_c; m_i = in_srci;
        m_en = in_lane_en; m_opc = in_opc; m_cmp = in_cmp;
        m_rm = (in_rm == 3'd7) ? csr_frm : in_rm;
        if (in_opc > 4'd8 || m_rm == 3'd5 || m_rm == 3'd6) begin
          m_valid = 1; e_illegal = 1; e_result = 0; e_resulti = 0; e_flags = 0;
        end else begin
          e_illegal = 0;
          m_cap = cyc + EXEC_LAT;
        end
      end
      e_fflags = m_nf;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [9:0] exp_ctrl;
  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready, !m_busy && !flush);
      check("out_valid", out_valid, m_valid);
      check("fflags", fflags, e_fflags);
      check("op_count", op_count, e_count);
      exp_ctrl = (m_busy && !m_valid) ? ref_ctrl(m_opc, m_cmp) : 10'd0;
      check("eu_ena", eu_ena, exp_ctrl[9:6]);
      if (m_busy && !m_valid) begin
        check("eu_sel1", eu_sel1, exp_ctrl[5:4]);
        check("eu_sel2", eu_sel2, exp_ctrl[3:1]);
        check("eu_op", eu_op, exp_ctrl[0]);
        check("eu_rm", eu_rm, m_rm);
        check("eu_data1", eu_data1, m_a);
        check("eu_data2", eu_data2, m_b);
        check("eu_data3", eu_data3, m_c);
        check("eu_datai", {eu_datai_1, eu_datai_0}, m_i);
      end
      if (m_valid) begin
        check("out_result", out_result, e_result);
        check("out_resulti", out_resulti, e_resulti);
        check("out_flags", out_flags, e_flags);
        check("out_illegal", out_illegal, e_illegal);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(logic [3:0] opc, logic [2:0] rm, logic [3:0] en,
                        logic [63:0] a, logic [63:0] b);
    in_opc = opc; in_rm = rm; in_lane_en = en; in_src_a = a; in_src_b = b;
    in_src_c = 64'h0; in_srci = 128'h0; in_cmp = 3'd0;
  endtask

  task automatic set_unit(logic [63:0] r, logic [3:0] dz, logic [3:0] nv);
    u_out = r; u_outi0 = 64'h0; u_outi1 = 64'h0;
    u_dz = dz; u_nv = nv; u_nx = 4'h0; u_of = 4'h0; u_uf = 4'h0;
  endtask

  // Counts edges until out_valid is seen; an expired bound is a failure.
  task automatic wait_valid(output int edges);
    edges = 0;
    while (!out_valid && edges < 40) begin
      tick();
      edges++;
    end
    if (!out_valid) check("wait_valid_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int          edges;
  logic [63:0] held;
  logic [4:0]  f_save;
  logic [CNT_W-1:0] c_save;

  initial begin
    repeat (3) tick();
    rst = 0;
    // Reset values
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_eu_ena", eu_ena, 4'h0);
    check("rst_eu_data1", eu_data1, 64'h0);
    check("rst_out_result", out_result, 64'h0);
    check("rst_fflags", fflags, 5'h0);
    check("rst_op_count", op_count, 16'h0);

    // ADD 1.0 + 1.0 in all lanes; result valid EXEC_LAT edges after the accept edge
    out_ready = 1;
    set_op(4'd0, 3'd0, 4'hF, {4{16'h3E00}}, {4{16'h3E00}});
    set_unit({4{16'h4000}}, 4'h0, 4'h0);
    in_valid = 1;
    tick();
    in_valid = 0;
    check("add_eu_ena", eu_ena, 4'b0001);
    wait_valid(edges);
    check("add_latency", edges, EXEC_LAT);
    check("add_result", out_result, 64'h4000_4000_4000_4000);
    check("add_flags", out_flags, 5'h0);
    tick();

    // DIV by zero with lanes 0 and 2 enabled
    set_op(4'd3, 3'd0, 4'b0101, {4{16'h3E00}}, 64'h0);
    set_unit({4{16'h7E00}}, 4'hF, 4'h0);
    in_valid = 1;
    tick();
    in_valid = 0;
    wait_valid(edges);
    check("div_result", out_result, 64'h3E00_7E00_3E00_7E00);
    check("div_flags", out_flags, 5'b01000);
    check("div_fflags", fflags, 5'b01000);
    tick();
    check("div_op_count", op_count, 16'd2);

    // Illegal opcode
    set_op(4'hC, 3'd0, 4'hF, {4{16'h1111}}, {4{16'h2222}});
    set_unit(64'hFFFF_FFFF_FFFF_FFFF, 4'hF, 4'hF);
    in_valid = 1;
    tick();
    in_valid = 0;
    check("ill_eu_ena", eu_ena, 4'h0);
    check("ill_out_illegal", out_illegal, 1'b1);
    check("ill_result", out_result, 64'h0);
    tick();
    check("ill_fflags", fflags, 5'b01000);
    check("ill_op_count", op_count, 16'd2);

    // Backpressure: result held while out_ready is low
    out_ready = 0;
    set_op(4'd1, 3'd2, 4'hF, 64'h0123_4567_89AB_CDEF, 64'h5555_AAAA_5555_AAAA);
    set_unit(64'hDEAD_BEEF_CAFE_F00D, 4'h0, 4'h0);
    in_valid = 1;
    tick();
    in_valid = 0;
    wait_valid(edges);
    held = out_result;
    check("bp_result", held, 64'hDEAD_BEEF_CAFE_F00D);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("bp_stable", out_result, held);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1;
    out_ready = 1;
    tick();
    check("bp_release_ready", in_ready, 1'b1);
    tick();
    in_valid = 0;
    check("bp_next_accept", eu_ena, 4'b0001);
    wait_valid(edges);
    tick();

    // Flush while in EXEC
    f_save = fflags;
    c_save = op_count;
    set_op(4'd2, 3'd1, 4'hF, 64'h1, 64'h2);
    set_unit(64'h0, 4'hF, 4'hF);
    in_valid = 1;
    tick();
    in_valid = 0;
    flush = 1;
    check("flush_in_ready_low", in_ready, 1'b0);
    tick();
    flush = 0;
    check("flush_out_valid", out_valid, 1'b0);
    tick();
    check("flush_in_ready_T3", in_ready, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("flush_no_valid", out_valid, 1'b0);
      tick();
    end
    check("flush_fflags", fflags, f_save);
    check("flush_op_count", op_count, c_save);

    // Dynamic rounding resolving to a reserved mode
    set_op(4'd0, 3'd7, 4'hF, 64'h0, 64'h0);
    csr_frm = 3'd5;
    in_valid = 1;
    tick();
    in_valid = 0;
    check("rmdyn_illegal", out_illegal, 1'b1);
    tick();
    csr_frm = 3'd0;

    // Asynchronous reset in EXEC
    set_op(4'd4, 3'd0, 4'hF, 64'h3, 64'h4);
    in_valid = 1;
    tick();
    in_valid = 0;
    #2;
    rst = 1;
    #1;
    check("arst_eu_ena", eu_ena, 4'h0);
    check("arst_eu_data1", eu_data1, 64'h0);
    check("arst_in_ready", in_ready, 1'b1);
    check("arst_op_count", op_count, 16'h0);
    check("arst_fflags", fflags, 5'h0);
    tick();
    rst = 0;

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_opc     = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      in_rm      = 3'($urandom_range(0, 7));
      csr_frm    = 3'($urandom_range(0, 7));
      in_cmp     = 3'($urandom_range(0, 7));
      in_lane_en = 4'($urandom_range(0, 15));
      in_src_a   = {$urandom(), $urandom()};
      in_src_b   = {$urandom(), $urandom()};
      in_src_c   = {$urandom(), $urandom()};
      in_srci    = {$urandom(), $urandom(), $urandom(), $urandom()};
      flush      = ($urandom_range(0, 29) == 0);
      fflags_clr = ($urandom_range(0, 19) == 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      u_out      = {$urandom(), $urandom()};
      u_outi0    = {$urandom(), $urandom()};
      u_outi1    = {$urandom(), $urandom()};
      u_nv = 4'($urandom_range(0, 15));
      u_nx = 4'($urandom_range(0, 15));
      u_of = 4'($urandom_range(0, 15));
      u_uf = 4'($urandom_range(0, 15));
      u_dz = 4'($urandom_range(0, 15));
      tick();
    end
    in_valid = 0; flush = 0; fflags_clr = 0; out_ready = 1;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
